// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: request, data-memory and response bundle of the memory stage.
// The slave modport is the sequencer and the master modport is the pipeline/memory side.
interface mem_stage_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [15:0] req_wdata;
    logic [31:0] req_pc;
    logic        stall;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_cs;
    logic [15:0] mem_rdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_pc_vld;
    logic [31:0] rsp_pc;
    logic        exc_stack;
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        output stall, mem_addr, mem_wdata, mem_rd, mem_wr, mem_cs,
               rsp_valid, rsp_data, rsp_pc_vld, rsp_pc, exc_stack
    );
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        input  stall, mem_addr, mem_wdata, mem_rd, mem_wr, mem_cs,
               rsp_valid, rsp_data, rsp_pc_vld, rsp_pc, exc_stack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage sequencer turning load/store/push/pop/call/ret into single-word
// memory strobes; owns a downward-growing stack pointer and splits 32-bit PC frames over two cycles.
module mem_stage_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int STACK_TOP = 2047,
    parameter int STACK_LIM = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_stage_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] sp
);
    typedef enum logic [1:0] {IDLE, CALL2, RET2} state_t;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;
    localparam logic [2:0] OP_CALL  = 3'd5;
    localparam logic [2:0] OP_RET   = 3'd6;
    localparam logic [ADDR_W-1:0] TOP     = ADDR_W'(STACK_TOP);
    localparam logic [ADDR_W-1:0] LIM     = ADDR_W'(STACK_LIM);
    localparam logic [ADDR_W-1:0] RET_MAX = ADDR_W'(STACK_TOP - 2);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [15:0]       lo_q, lo_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic              rsp_pc_vld_q, rsp_pc_vld_d;
    logic [31:0]       rsp_pc_q, rsp_pc_d;
    logic              exc_q, exc_d;
    logic              rd, wr, stall_c;
    logic [ADDR_W-1:0] addr, sp_inc, sp_dec;
    logic [15:0]       wdata;
    logic              unused_addr_hi;

    assign sp_inc         = sp_q + ADDR_W'(1);
    assign sp_dec         = sp_q - ADDR_W'(1);
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    // lo_q carries the CALL low PC half into CALL2, or the popped RET low word into RET2
    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        lo_d         = lo_q;
        rd           = 1'b0;
        wr           = 1'b0;
        stall_c      = 1'b0;
        addr         = sp_q;
        wdata        = bus.req_wdata;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_pc_vld_d = 1'b0;
        rsp_pc_d     = rsp_pc_q;
        exc_d        = 1'b0;
        case (state_q)
            CALL2: begin
                wr      = 1'b1;
                wdata   = lo_q;
                sp_d    = sp_dec;
                state_d = IDLE;
            end
            RET2: begin
                rd           = 1'b1;
                addr         = sp_inc;
                sp_d         = sp_inc;
                state_d      = IDLE;
                rsp_valid_d  = 1'b1;
                rsp_pc_vld_d = 1'b1;
                rsp_pc_d     = {bus.mem_rdata, lo_q};
            end
            default: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_LOAD: begin
                            rd          = 1'b1;
                            addr        = bus.req_addr[ADDR_W-1:0];
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = bus.mem_rdata;
                        end
                        OP_STORE: begin
                            wr   = 1'b1;
                            addr = bus.req_addr[ADDR_W-1:0];
                        end
                        OP_PUSH: begin
                            exc_d = sp_q < LIM;
                            wr    = !exc_d;
                            sp_d  = exc_d ? sp_q : sp_dec;
                        end
                        OP_POP: begin
                            exc_d       = sp_q == TOP;
                            rd          = !exc_d;
                            addr        = sp_inc;
                            sp_d        = exc_d ? sp_q : sp_inc;
                            rsp_valid_d = !exc_d;
                            rsp_data_d  = exc_d ? rsp_data_q : bus.mem_rdata;
                        end
                        OP_CALL: begin
                            exc_d   = sp_q <= LIM;
                            wr      = !exc_d;
                            stall_c = !exc_d;
                            wdata   = bus.req_pc[31:16];
                            lo_d    = exc_d ? lo_q : bus.req_pc[15:0];
                            sp_d    = exc_d ? sp_q : sp_dec;
                            state_d = exc_d ? IDLE : CALL2;
                        end
                        OP_RET: begin
                            exc_d   = sp_q > RET_MAX;
                            rd      = !exc_d;
                            stall_c = !exc_d;
                            addr    = sp_inc;
                            lo_d    = exc_d ? lo_q : bus.mem_rdata;
                            sp_d    = exc_d ? sp_q : sp_inc;
                            state_d = exc_d ? IDLE : RET2;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sp_q         <= TOP;
            lo_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_pc_vld_q <= 1'b0;
            rsp_pc_q     <= '0;
            exc_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            lo_q         <= lo_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_pc_vld_q <= rsp_pc_vld_d;
            rsp_pc_q     <= rsp_pc_d;
            exc_q        <= exc_d;
        end
    end

    // strobes are gated by reset so an abandoned CALL2/RET2 drops them at once
    assign bus.mem_rd     = rst_n & rd;
    assign bus.mem_wr     = rst_n & wr;
    assign bus.mem_cs     = rst_n & (rd | wr);
    assign bus.stall      = rst_n & stall_c;
    assign bus.mem_addr   = {{(32-ADDR_W){1'b0}}, addr};
    assign bus.mem_wdata  = wdata;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_pc_vld = rsp_pc_vld_q;
    assign bus.rsp_pc     = rsp_pc_q;
    assign bus.exc_stack  = exc_q;
    assign sp             = sp_q;
endmodule
